// File: rtl/shift_pkg.sv
// Shared types and constants for the shift issue queue and its barrel shifter.
// The FIFO stores shift_req_t, so the DATA_W/AMT_W below must match the
// widths the queue is built with.
package shift_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [AMT_W-1:0]  amt;
        logic              dir;
    } shift_req_t;

endpackage

// File: rtl/shift_issue_queue_if.sv
// Request/result handshake bundle for the shift issue queue.
// slave is the queue's view; master is the view of the request source and
// result consumer that sit around it.
interface shift_issue_queue_if #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5,
    parameter int DEPTH  = 4
);
    localparam int COUNT_W = $clog2(DEPTH) + 1;

    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic [AMT_W-1:0]   in_amt;
    logic               in_dir;

    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [AMT_W-1:0]   out_amt;
    logic               out_dir;

    logic [COUNT_W-1:0] count;

    modport master (
        output in_valid, in_data, in_amt, in_dir, out_ready,
        input  in_ready, out_valid, out_data, out_amt, out_dir, count
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_dir, out_ready,
        output in_ready, out_valid, out_data, out_amt, out_dir, count
    );

endinterface

// File: rtl/barrel_shifter.sv
// Combinational logical barrel shifter, zero fill in both directions.
// One mux stage per amount bit, stage i shifting by 2**i.
module barrel_shifter
    import shift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic [AMT_W-1:0]  shift_amt,
    input  logic              dir,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] stage [AMT_W+1];

    // Log-depth shift network: each amount bit selects a power-of-two shift.
    always_comb begin
        stage[0] = data_in;
        for (int i = 0; i < AMT_W; i++) begin
            if (shift_amt[i]) begin
                if (dir == DIR_RIGHT) begin
                    stage[i+1] = stage[i] >> (1 << i);
                end else begin
                    stage[i+1] = stage[i] << (1 << i);
                end
            end else begin
                stage[i+1] = stage[i];
            end
        end
    end

    assign data_out = stage[AMT_W];

endmodule

// File: rtl/shift_issue_queue.sv
// Sequential front end for the barrel shifter: a DEPTH-entry request FIFO
// whose head feeds the shifter, followed by a valid/ready result register.
// Full/empty come from the occupancy counter only; the pointers just wrap.
// in_ready looks at the counter alone so a full queue never accepts in the
// same cycle it pops, and out_ready has no combinational path to in_ready.
module shift_issue_queue #(
    parameter int DATA_W = shift_pkg::DATA_W,
    parameter int AMT_W  = shift_pkg::AMT_W,
    parameter int DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst,
    shift_issue_queue_if.slave bus
);
    import shift_pkg::*;

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = PTR_W + 1;

    shift_req_t         fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [COUNT_W-1:0] count_q;

    shift_req_t         in_req;
    shift_req_t         head;
    logic [DATA_W-1:0]  head_result;

    logic               in_ready_w;
    logic               push;
    logic               load;

    logic               out_valid_q;
    logic [DATA_W-1:0]  out_data_q;
    logic [AMT_W-1:0]   out_amt_q;
    logic               out_dir_q;

    assign in_ready_w = (count_q < COUNT_W'(DEPTH));
    assign push       = bus.in_valid && in_ready_w;
    assign load       = (count_q != '0) && (!out_valid_q || bus.out_ready);

    // Pack the incoming request into the storage format.
    always_comb begin
        in_req      = '0;
        in_req.data = bus.in_data;
        in_req.amt  = bus.in_amt;
        in_req.dir  = bus.in_dir;
    end

    assign head = fifo_mem[rd_ptr];

    barrel_shifter #(
        .DATA_W (DATA_W),
        .AMT_W  (AMT_W)
    ) u_barrel_shifter (
        .data_in   (head.data),
        .shift_amt (head.amt),
        .dir       (head.dir),
        .data_out  (head_result)
    );

    // FIFO storage; deliberately not reset, only the pointers and count are.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_req;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, load})
                2'b10:   count_q <= count_q + COUNT_W'(1);
                2'b01:   count_q <= count_q - COUNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Result register: load the shifted head, drop valid when drained,
    // hold the payload while stalled or after draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_amt_q   <= '0;
            out_dir_q   <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= head_result;
            out_amt_q   <= head.amt;
            out_dir_q   <= head.dir;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_amt   = out_amt_q;
    assign bus.out_dir   = out_dir_q;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_shift_issue_queue.sv
// Self-checking bench for shift_issue_queue: a queue-of-results reference
// model checked every cycle, a table of boundary shift vectors, directed
// backpressure / push-pop / mid-operation reset sequences and a random phase.
module tb_shift_issue_queue;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    shift_issue_queue_if #(.DATA_W(32), .AMT_W(5), .DEPTH(DEPTH)) bus ();

    shift_issue_queue #(.DATA_W(32), .AMT_W(5), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  amt;
        logic        dir;
    } item_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  amt;
        logic        dir;
        logic [31:0] exp_data;
    } vec_t;

    item_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    m_cnt = 0;
    logic  m_ov  = 1'b0;
    int    n_pop = 0;

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] a,
                                              input logic dir);
        return dir ? (d >> a) : (d << a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic put(input logic [31:0] d, input logic [4:0] a, input logic dir);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_dir   = dir;
    endtask

    task automatic idle_in();
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        bus.in_amt   = 5'($urandom);
        bus.in_dir   = 1'($urandom);
    endtask

    // One clock: check DUT against the model, advance the model, cross the edge.
    task automatic step();
        logic        pre_push, pre_pop, pre_load, pre_stall;
        logic [31:0] pd;
        logic [4:0]  pa;
        logic        pdir;
        item_t       it;
        chk("in_ready", bus.in_ready, (m_cnt < DEPTH));
        chk("count", bus.count, m_cnt);
        chk("out_valid", bus.out_valid, m_ov);
        pre_push  = bus.in_valid && (m_cnt < DEPTH);
        pre_pop   = m_ov && bus.out_ready;
        pre_load  = (m_cnt > 0) && (!m_ov || bus.out_ready);
        pre_stall = m_ov && !bus.out_ready;
        pd   = bus.out_data;
        pa   = bus.out_amt;
        pdir = bus.out_dir;
        if (pre_pop && exp_q.size() > 0) begin
            it = exp_q.pop_front();
            chk("result_data", pd, it.data);
            chk("result_amt", pa, it.amt);
            chk("result_dir", pdir, it.dir);
            n_pop++;
        end
        if (pre_push) begin
            it.data = ref_shift(bus.in_data, bus.in_amt, bus.in_dir);
            it.amt  = bus.in_amt;
            it.dir  = bus.in_dir;
            exp_q.push_back(it);
        end
        m_cnt = m_cnt + (pre_push ? 1 : 0) - (pre_load ? 1 : 0);
        if (pre_load)     m_ov = 1'b1;
        else if (pre_pop) m_ov = 1'b0;
        @(posedge clk);
        #1;
        if (pre_stall) begin
            chk("stall_data", bus.out_data, pd);
            chk("stall_amt", bus.out_amt, pa);
            chk("stall_dir", bus.out_dir, pdir);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        m_cnt = 0;
        m_ov  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        bus.out_ready = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_amt", bus.out_amt, 0);
        chk("rst_out_dir", bus.out_dir, 0);
        rst = 1'b0;
    endtask

    // Consume everything in flight, bounded by a cycle budget.
    task automatic drain(input string name);
        idle_in();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
        chk({name, "_drain_timeout"}, exp_q.size(), 0);
        step();
    endtask

    vec_t vecs[8];

    initial begin
        int run;
        int maxrun;

        vecs[0] = '{32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000};
        vecs[1] = '{32'hFFFF_FFFF, 5'd31, 1'b1, 32'h0000_0001};
        vecs[2] = '{32'hA5A5_A5A5, 5'd0,  1'b0, 32'hA5A5_A5A5};
        vecs[3] = '{32'hA5A5_A5A5, 5'd0,  1'b1, 32'hA5A5_A5A5};
        vecs[4] = '{32'hF0F0_F0F0, 5'd4,  1'b0, 32'h0F0F_0F00};
        vecs[5] = '{32'hF0F0_F0F0, 5'd4,  1'b1, 32'h0F0F_0F0F};
        vecs[6] = '{32'h1234_5678, 5'd16, 1'b1, 32'h0000_1234};
        vecs[7] = '{32'h1234_5678, 5'd8,  1'b0, 32'h3456_7800};

        rst = 1'b1;
        idle_in();
        bus.out_ready = 1'b0;
        do_reset();

        // Basic path and first-result latency.
        bus.out_ready = 1'b1;
        put(32'h8000_0001, 5'd1, 1'b1);
        step();
        idle_in();
        chk("t1_valid_after_push_edge", bus.out_valid, 0);
        chk("t1_count_after_push_edge", bus.count, 1);
        step();
        chk("t1_out_valid", bus.out_valid, 1);
        chk("t1_out_data", bus.out_data, 32'h4000_0000);
        chk("t1_out_amt", bus.out_amt, 1);
        chk("t1_out_dir", bus.out_dir, 1);
        drain("t1");

        // Boundary shift table.
        bus.out_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            put(vecs[v].data, vecs[v].amt, vecs[v].dir);
            step();
            idle_in();
            step();
            chk("vec_valid", bus.out_valid, 1);
            chk("vec_data", bus.out_data, vecs[v].exp_data);
            step();
        end
        drain("vec");

        // Fill and backpressure.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            put(32'hC0DE_0100 + 32'(i), 5'(i + 1), 1'(i));
            step();
        end
        chk("t2_count_full", bus.count, 4);
        chk("t2_in_ready_full", bus.in_ready, 0);
        chk("t2_out_valid", bus.out_valid, 1);
        put(32'hDEAD_BEEF, 5'd3, 1'b0);
        repeat (3) step();
        chk("t2_count_held", bus.count, 4);
        idle_in();
        n_pop = 0;
        drain("t2");
        chk("t2_pops", n_pop, 5);
        chk("t2_out_valid_end", bus.out_valid, 0);
        chk("t2_count_end", bus.count, 0);

        // Streaming at one result per cycle.
        bus.out_ready = 1'b1;
        n_pop = 0;
        run = 0;
        maxrun = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) put($urandom, 5'($urandom), 1'($urandom));
            else       idle_in();
            step();
            run = bus.out_valid ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
        end
        chk("t3_pops", n_pop, 8);
        chk("t3_consecutive_valid", maxrun, 8);
        drain("t3");

        // Simultaneous push and load at count=2.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(32'h5000_0000 + 32'(i), 5'(i), 1'(i));
            step();
        end
        chk("t5_count_pre", bus.count, 2);
        chk("t5_valid_pre", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        put(32'h5000_00AA, 5'd7, 1'b1);
        step();
        chk("t5_count_same", bus.count, 2);
        drain("t5");

        // Reset in the middle of traffic.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(32'h7700_0000 + 32'(i << 8), 5'(i + 2), 1'(i));
            step();
        end
        idle_in();
        chk("t6_count_pre", bus.count, 3);
        chk("t6_valid_pre", bus.out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_out_valid", bus.out_valid, 0);
        chk("t6_rst_count", bus.count, 0);
        chk("t6_rst_in_ready", bus.in_ready, 1);
        chk("t6_rst_out_data", bus.out_data, 0);
        #1;
        rst = 1'b0;
        clear_model();
        bus.out_ready = 1'b1;
        put(32'h0000_F00D, 5'd4, 1'b0);
        step();
        idle_in();
        step();
        chk("t6_new_data", bus.out_data, 32'h000F_00D0);
        n_pop = 0;
        drain("t6");
        chk("t6_pops", n_pop, 1);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(1, 0) != 0) put($urandom, 5'($urandom), 1'($urandom));
            else                           idle_in();
            bus.out_ready = ($urandom_range(3, 0) != 0);
            step();
        end
        drain("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_issue_queue.md
Name: shift_issue_queue

Overview:
Sequential front end for the team's combinational 32-bit barrel shifter.
- Accepts shift requests {data, amount, direction} over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Presents the FIFO head to an internal barrel_shifter instance and registers each result into a valid/ready output stage.
- Sits between the request source (decode/issue logic) and the result consumer (writeback).

Parameters:
DATA_W, 32, operand/result width
AMT_W, 5, shift-amount width; DATA_W = 2**AMT_W
DEPTH, 4, FIFO entries; power of 2, >= 2

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  request present
in_ready  output  1  queue can accept a request
in_data  input  DATA_W  operand
in_amt  input  AMT_W  shift amount
in_dir  input  1  1 = logical right, 0 = logical left
out_valid  output  1  result register holds a valid result
out_ready  input  1  consumer accepts the result
out_data  output  DATA_W  shifted result
out_amt  output  AMT_W  amount echoed with the result
out_dir  output  1  direction echoed with the result
count  output  $clog2(DEPTH)+1  FIFO occupancy, excludes the output register

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, out_valid=0, out_data=0, out_amt=0, out_dir=0. in_ready=1 while rst is high and after release. FIFO storage is not cleared. Reset mid-operation discards all queued and registered results with no partial output.
- Push: when in_valid && in_ready at a clk edge, write {in_data,in_amt,in_dir} at wr_ptr; wr_ptr increments modulo DEPTH.
- in_ready = (count < DEPTH). It depends on count only: a full FIFO does not accept even in a cycle where it pops. There is no combinational path from out_ready to in_ready.
- Shift: the head entry drives barrel_shifter combinationally.
  - dir=1: logical right. dir=0: logical left.
  - Zero fill; amt=0 passes data unchanged.
- Load: when count>0 && (!out_valid || out_ready), at the clk edge:
  - out_data/out_amt/out_dir load the head result, out_valid=1, rd_ptr increments modulo DEPTH.
- Drain: when out_valid && out_ready and no load occurs, out_valid becomes 0. out_data/out_amt/out_dir keep their last value.
- Stall: while out_valid && !out_ready, out_data, out_amt and out_dir are held stable.
- count: +1 on push only, -1 on load only, unchanged on simultaneous push and load. It never exceeds DEPTH and never goes below 0.
- Latency: a request accepted at edge N, into an empty queue with out_valid=0, is registered at edge N+1, so out_valid=1 after N+1.
- Throughput: one result per cycle sustained when in_valid=1 and out_ready=1.
- Total capacity is DEPTH+1 requests (FIFO plus output register).
- Ordering: results leave strictly in acceptance order.
- Wrap-around: pointers are AMT-independent, $clog2(DEPTH) bits wide, and wrap naturally. Full/empty are derived from count, never from pointer equality.
- Inputs are sampled only on handshake. in_data/in_amt/in_dir are don't-care when in_valid=0.

Decomposition:
- Package shift_pkg holds DATA_W/AMT_W defaults, DIR_LEFT=1'b0, DIR_RIGHT=1'b1, and a packed shift_req_t {data, amt, dir} used for FIFO storage.
- The one natural sub-module is the existing barrel_shifter (ports data_in, shift_amt, dir, data_out), instanced unchanged.
- FIFO and output register stay in this module.

Test Plan:
1. Basic path: reset, out_ready=1, push 0x8000_0001/amt 1/dir 1 → out_valid=1 after the next edge; out_data=0x4000_0000, out_amt=1, out_dir=1.
2. Fill and backpressure: out_ready=0, in_valid=1 with 6 distinct requests.
   - First request lands in the output register; the next 4 give count=4 and in_ready=0; the 6th is held.
   - out_data is stable throughout the stall.
   - Raise out_ready → 5 results in order, then out_valid=0 and count=0.
3. Streaming: in_valid=1 and out_ready=1 for 8 random requests → 8 consecutive out_valid cycles, in order, each matching the data<<amt or data>>amt reference model.
4. Boundary shifts:
   - 0x0000_0001 left 31 → 0x8000_0000.
   - 0xFFFF_FFFF right 31 → 0x0000_0001.
   - 0xA5A5_A5A5 amt 0 in both directions → 0xA5A5_A5A5.
5. Simultaneous push/pop at count=2: one push and one load in the same cycle → count stays 2 and ordering is preserved.
6. Reset mid-operation: with count=3 and out_valid=1, pulse rst between edges.
   - Immediately out_valid=0, count=0, in_ready=1.
   - After release, a new request returns only its own result.
